// File: rtl/mips_regfile_sb_pkg.sv
// Shared constants, address-width helper and the write-trace record for the
// MIPS general-purpose register file.
package mips_rf_pkg;
    localparam int DEF_DW   = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);

    function automatic int rf_aw(input int nreg);
        return (nreg <= 1) ? 1 : $clog2(nreg);
    endfunction

    typedef struct packed {
        logic              valid;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
        logic [31:0]       pc;
    } trace_t;
endpackage

// File: rtl/mips_regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write
// ports, issue reservation and the registered write trace.
interface mips_regfile_sb_if
    import mips_rf_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NREG   = DEF_NREG,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = rf_aw(NREG);

    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic [NUM_WR-1:0]    wr_en;
    logic [NUM_WR*AW-1:0] wr_addr;
    logic [NUM_WR*DW-1:0] wr_data;
    logic [NUM_WR*32-1:0] wr_pc;
    logic [NUM_WR-1:0]    wr_sb;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic                 issue_ready;
    logic [NUM_WR-1:0]    trace_valid;
    logic [NUM_WR*AW-1:0] trace_addr;
    logic [NUM_WR*DW-1:0] trace_data;
    logic [NUM_WR*32-1:0] trace_pc;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_pc, wr_sb, issue_en, issue_addr,
        input  rd_data, rd_busy, issue_ready, trace_valid, trace_addr, trace_data, trace_pc
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, wr_sb, issue_en, issue_addr,
        output rd_data, rd_busy, issue_ready, trace_valid, trace_addr, trace_data, trace_pc
    );
endinterface

// File: rtl/mips_regfile_sb_pending_ctr.sv
// Per-register pending-write counter: one increment (issue) and up to two
// decrements (retires) per cycle, clamped to [0, 2^PW-1].
module rf_pending_ctr #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          dec0,
    input  logic          dec1,
    output logic [PW-1:0] cnt
);
    localparam logic [PW+1:0] MAX = {2'b00, {PW{1'b1}}};

    logic [PW+1:0] up;
    logic [PW+1:0] ndec;
    logic [PW+1:0] diff;

    always_comb begin
        up   = {2'b00, cnt} + (PW+2)'(inc);
        ndec = (PW+2)'(dec0) + (PW+2)'(dec1);
        diff = up - ndec;
    end

    // A retire with nothing pending is a plain unscoreboarded write: floor at 0.
    always_ff @(posedge clk) begin
        if (reset)            cnt <= '0;
        else if (up < ndec)   cnt <= '0;
        else if (diff > MAX)  cnt <= '1;
        else                  cnt <= diff[PW-1:0];
    end
endmodule

// File: rtl/mips_regfile_sb.sv
// Multi-port GPR file with write-through bypass, hardwired zero register,
// pending-write scoreboard and a registered commit trace.
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int NREG     = DEF_NREG,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int PW       = 2
) (
    input logic clk,
    input logic reset,
    mips_regfile_sb_if.slave bus
);
    localparam int AW = rf_aw(NREG);

    logic [NREG-1:0][DW-1:0]   mem;
    logic [NREG-1:0][PW-1:0]   pend;
    logic [NUM_RD-1:0][AW-1:0] ra;
    logic [NUM_RD-1:0][DW-1:0] rdat;
    logic [NUM_RD-1:0]         busy;
    logic [NUM_WR-1:0][AW-1:0] wa;
    logic [NUM_WR-1:0][DW-1:0] wd;
    logic [NUM_WR-1:0]         wr_ok;
    logic                      issue_ok;

    assign ra          = bus.rd_addr;
    assign wa          = bus.wr_addr;
    assign wd          = bus.wr_data;
    assign bus.rd_data = rdat;
    assign bus.rd_busy = busy;

    always_comb begin
        for (int j = 0; j < NUM_WR; j++)
            wr_ok[j] = bus.wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0);
    end

    // Later write ports override earlier ones, both in storage and in the bypass.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (wr_ok[j]) mem[wa[j]] <= wd[j];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdat[i] = mem[ra[i]];
            for (int j = 0; j < NUM_WR; j++)
                if (wr_ok[j] && wa[j] == ra[i]) rdat[i] = wd[j];
            busy[i] = (pend[ra[i]] != '0);
        end
    end

    assign issue_ok        = (pend[bus.issue_addr] != '1);
    assign bus.issue_ready = issue_ok;

    for (genvar r = 0; r < NREG; r++) begin : g_ctr
        if (ZERO_REG != 0 && r == 0) begin : g_zero
            assign pend[r] = '0;
        end else begin : g_live
            logic       inc;
            logic [1:0] dec;
            assign inc    = bus.issue_en & issue_ok & (bus.issue_addr == AW'(r));
            assign dec[0] = bus.wr_en[0] & bus.wr_sb[0] & (wa[0] == AW'(r));
            if (NUM_WR > 1) begin : g_dec1
                assign dec[1] = bus.wr_en[1] & bus.wr_sb[1] & (wa[1] == AW'(r));
            end else begin : g_nodec1
                assign dec[1] = 1'b0;
            end
            rf_pending_ctr #(.PW(PW)) u_ctr (
                .clk  (clk),
                .reset(reset),
                .inc  (inc),
                .dec0 (dec[0]),
                .dec1 (dec[1]),
                .cnt  (pend[r])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.trace_valid <= '0;
            bus.trace_addr  <= '0;
            bus.trace_data  <= '0;
            bus.trace_pc    <= '0;
        end else begin
            bus.trace_valid <= wr_ok;
            bus.trace_addr  <= bus.wr_addr;
            bus.trace_data  <= bus.wr_data;
            bus.trace_pc    <= bus.wr_pc;
        end
    end
endmodule
